// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path.
//   - opcode constants for the three supported operations
//   - header size and minimum packet length (bytes, header included)
//   - parser state enum
//   - header_ok(): header acceptance rule, parameterised on the largest length
package alu_pkg;

   localparam logic [7:0]  OpAdd       = 8'hAD;
   localparam logic [7:0]  OpMul       = 8'h63;
   localparam logic [7:0]  OpDiv       = 8'h5B;
   localparam logic [15:0] HeaderBytes = 16'd4;
   localparam logic [15:0] MinLength   = 16'd12;

   typedef enum logic [1:0] {
      StHeader  = 2'd0,
      StOperand = 2'd1,
      StDiscard = 2'd2
   } parser_state_e;

   // Division takes exactly two operands, so its only legal length is the minimum.
   function automatic logic header_ok(input logic [7:0]  opcode,
                                      input logic [15:0] length,
                                      input logic [15:0] max_length);
      logic known;
      known = (opcode == OpAdd) || (opcode == OpMul) || (opcode == OpDiv);
      return known
          && (length[1:0] == 2'b00)
          && (length >= MinLength)
          && (length <= max_length)
          && ((opcode != OpDiv) || (length == MinLength));
   endfunction

endpackage

// File: rtl/alu_cmd_parser.sv
// Byte-stream to operand-stream parser for ALU command packets.
// Packet: opcode, reserved, length (LSB first, header included), then
// 32-bit operands sent LSB first.
//
// Ports
//   clk_i      in   clock, rising edge
//   reset_i    in   synchronous active-high reset
//   data_i     in   [7:0]  received byte
//   valid_i    in   data_i valid
//   ready_o    out  parser accepts data_i this cycle
//   operand_o  out  [31:0] assembled operand
//   opcode_o   out  [7:0]  opcode of the packet being delivered
//   first_o    out  operand_o is the first operand of its packet
//   last_o     out  operand_o is the final operand of its packet
//   valid_o    out  operand_o/first_o/last_o valid
//   ready_i    in   ALU consumes the operand
//   error_o    out  one-cycle pulse on a rejected header
//
// state     | meaning
// StHeader  | collecting the 4 header bytes, validated on the 4th
// StOperand | assembling operands; input stalls while an operand is pending
// StDiscard | dropping the payload of a rejected packet
module alu_cmd_parser
   import alu_pkg::*;
#(
   parameter logic [15:0] MaxLength = 16'd1024
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [7:0]  data_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [31:0] operand_o,
   output logic [7:0]  opcode_o,
   output logic        first_o,
   output logic        last_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        error_o
);

   parser_state_e state_q, state_d;

   logic [1:0]  byte_cnt_q;
   logic [7:0]  hdr_opcode_q;
   logic [7:0]  len_lo_q;
   logic [15:0] remaining_q;
   logic [23:0] asm_q;
   logic        first_pend_q;

   logic        byte_fire;
   logic        op_fire;
   logic [15:0] hdr_len;
   logic        hdr_valid;
   logic        hdr_done;

   assign ready_o   = (state_q != StOperand) || !valid_o;
   assign byte_fire = valid_i && ready_o;
   assign op_fire   = valid_o && ready_i;
   assign hdr_len   = {data_i, len_lo_q};
   assign hdr_valid = header_ok(hdr_opcode_q, hdr_len, MaxLength);
   assign hdr_done  = (state_q == StHeader) && byte_fire && (byte_cnt_q == 2'd3);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StHeader;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StHeader: begin
            if (hdr_done) begin
               if (hdr_valid) begin
                  state_d = StOperand;
               end else if (hdr_len >= 16'd8) begin
                  state_d = StDiscard;
               end
            end
         end
         StOperand: begin
            if (op_fire && last_o) begin
               state_d = StHeader;
            end
         end
         StDiscard: begin
            if (byte_fire && (remaining_q == 16'd1)) begin
               state_d = StHeader;
            end
         end
         default: state_d = StHeader;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         byte_cnt_q   <= 2'd0;
         hdr_opcode_q <= 8'h00;
         len_lo_q     <= 8'h00;
         remaining_q  <= 16'd0;
         asm_q        <= 24'd0;
         first_pend_q <= 1'b0;
         operand_o    <= 32'd0;
         opcode_o     <= 8'h00;
         first_o      <= 1'b0;
         last_o       <= 1'b0;
         valid_o      <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         error_o <= 1'b0;
         if (op_fire) begin
            valid_o <= 1'b0;
            first_o <= 1'b0;
            last_o  <= 1'b0;
         end
         if (byte_fire) begin
            case (state_q)
               StHeader: begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  case (byte_cnt_q)
                     2'd0: hdr_opcode_q <= data_i;
                     2'd2: len_lo_q     <= data_i;
                     2'd3: begin
                        if (hdr_valid) begin
                           opcode_o     <= hdr_opcode_q;
                           remaining_q  <= hdr_len - HeaderBytes;
                           first_pend_q <= 1'b1;
                        end else begin
                           error_o     <= 1'b1;
                           // Short bad headers carry no payload we could trust to skip.
                           remaining_q <= (hdr_len >= 16'd8) ? (hdr_len - HeaderBytes) : 16'd0;
                        end
                     end
                     default: ;
                  endcase
               end
               StOperand: begin
                  byte_cnt_q  <= byte_cnt_q + 2'd1;
                  remaining_q <= remaining_q - 16'd1;
                  asm_q       <= {data_i, asm_q[23:8]};
                  if (byte_cnt_q == 2'd3) begin
                     operand_o    <= {data_i, asm_q};
                     valid_o      <= 1'b1;
                     first_o      <= first_pend_q;
                     last_o       <= (remaining_q == 16'd1);
                     first_pend_q <= 1'b0;
                  end
               end
               StDiscard: begin
                  remaining_q <= remaining_q - 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_parser.sv
module tb_alu_cmd_parser;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [7:0]  data_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] operand_o;
   logic [7:0]  opcode_o;
   logic        first_o;
   logic        last_o;
   logic        valid_o;
   logic        ready_i;
   logic        error_o;

   always #5 clk_i = ~clk_i;

   alu_cmd_parser #(.MaxLength(16'd1024)) dut (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .data_i   (data_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .operand_o(operand_o),
      .opcode_o (opcode_o),
      .first_o  (first_o),
      .last_o   (last_o),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .error_o  (error_o)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  tx_q[$];
   logic [31:0] exp_op_q[$];
   logic [1:0]  exp_fl_q[$];
   logic [7:0]  exp_opc_q[$];
   int          exp_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: builds the byte stream of one packet and records what
   // the parser must produce for it.
   task automatic build_packet(input logic [7:0] opc, input int len, input bit fixed);
      bit          ok;
      int          n;
      logic [31:0] w;
      ok = (opc == 8'hAD || opc == 8'h63 || opc == 8'h5B) && (len % 4 == 0)
           && (len >= 12) && (len <= 1024) && (opc != 8'h5B || len == 12);
      tx_q.push_back(opc);
      tx_q.push_back(8'($urandom));
      tx_q.push_back(8'(len));
      tx_q.push_back(8'(len >> 8));
      if (ok) begin
         n = (len - 4) / 4;
         for (int i = 0; i < n; i++) begin
            w = fixed ? 32'(i + 1) : $urandom;
            for (int b = 0; b < 4; b++) tx_q.push_back(8'(w >> (8 * b)));
            exp_op_q.push_back(w);
            exp_fl_q.push_back({(i == 0), (i == n - 1)});
            exp_opc_q.push_back(opc);
         end
      end else begin
         exp_err++;
         if (len >= 8) begin
            for (int i = 0; i < len - 4; i++) tx_q.push_back(8'($urandom));
         end
      end
   endtask

   task automatic run(input int stall, input bit rnd);
      int cyc      = 0;
      int err_seen = 0;
      int wait_cnt = 0;
      int drain    = 0;
      while (drain < 4) begin
         @(negedge clk_i);
         if (tx_q.size() > 0 && (!rnd || $urandom_range(3) != 0)) begin
            valid_i = 1'b1;
            data_i  = tx_q[0];
         end else begin
            valid_i = 1'b0;
            data_i  = 8'($urandom);
         end
         if (valid_o) ready_i = (wait_cnt >= stall) && (!rnd || $urandom_range(2) != 0);
         else         ready_i = 1'($urandom);
         if (error_o) err_seen++;
         if (valid_o) begin
            check("ready_o while operand pending", 32'(ready_o), 32'd0);
            if (exp_op_q.size() == 0) begin
               check("unexpected valid_o", 32'(valid_o), 32'd0);
            end else begin
               check("operand_o", operand_o, exp_op_q[0]);
               if (ready_i) begin
                  check("first_o/last_o", 32'({first_o, last_o}), 32'(exp_fl_q[0]));
                  check("opcode_o", 32'(opcode_o), 32'(exp_opc_q[0]));
                  void'(exp_op_q.pop_front());
                  void'(exp_fl_q.pop_front());
                  void'(exp_opc_q.pop_front());
                  wait_cnt = 0;
               end else begin
                  wait_cnt++;
               end
            end
         end
         if (valid_i && ready_o) void'(tx_q.pop_front());
         if (tx_q.size() == 0 && exp_op_q.size() == 0) drain++;
         cyc++;
         if (cyc > 20000) begin
            check("run timeout", 32'd1, 32'd0);
            tx_q.delete();
            exp_op_q.delete();
            exp_fl_q.delete();
            exp_opc_q.delete();
            break;
         end
      end
      valid_i = 1'b0;
      ready_i = 1'b0;
      check("error_o pulse cycles", 32'(err_seen), 32'(exp_err));
      check("valid_o idle after run", 32'(valid_o), 32'd0);
      exp_err = 0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_i = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " ready_o"},   32'(ready_o),   32'd1);
      check({tag, " valid_o"},   32'(valid_o),   32'd0);
      check({tag, " first_o"},   32'(first_o),   32'd0);
      check({tag, " last_o"},    32'(last_o),    32'd0);
      check({tag, " error_o"},   32'(error_o),   32'd0);
      check({tag, " operand_o"}, operand_o,      32'd0);
      check({tag, " opcode_o"},  32'(opcode_o),  32'd0);
   endtask

   initial begin
      logic [7:0] opc_tbl[5];
      int         len_tbl[10];
      logic [7:0] pend[8];
      opc_tbl = '{8'hAD, 8'h63, 8'h5B, 8'h11, 8'h00};
      len_tbl = '{12, 16, 20, 28, 8, 4, 13, 0, 32, 12};
      pend    = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

      reset_i = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      data_i  = 8'h00;
      repeat (3) @(negedge clk_i);
      reset_i = 1'b0;
      check_reset_state("reset");

      // Add, two operands 1 and 2
      build_packet(8'hAD, 12, 1'b1);
      run(0, 1'b0);

      // Mul, six operands, 20-cycle stall on each
      build_packet(8'h63, 28, 1'b0);
      run(20, 1'b0);

      // Div with bad length, payload discarded, then a good add
      build_packet(8'h5B, 16, 1'b0);
      build_packet(8'hAD, 12, 1'b0);
      run(0, 1'b0);

      // Unknown opcode with short length: no discard
      build_packet(8'h11, 4, 1'b0);
      build_packet(8'hAD, 12, 1'b1);
      run(0, 1'b0);

      // Boundaries: largest legal length, just over it, minimal discard, zero length, legal div
      build_packet(8'h63, 1024, 1'b0);
      build_packet(8'hAD, 1028, 1'b0);
      build_packet(8'h63, 8, 1'b0);
      build_packet(8'hAD, 0, 1'b0);
      build_packet(8'h5B, 12, 1'b0);
      build_packet(8'hAD, 20, 1'b0);
      run(0, 1'b1);

      // Reset after two operand bytes: partial operand dropped
      tx_q = {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22};
      run(0, 1'b0);
      do_reset();
      check_reset_state("mid-packet reset");
      build_packet(8'hAD, 12, 1'b0);
      run(0, 1'b0);

      // Reset with a completed operand still pending
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         valid_i = 1'b1;
         data_i  = pend[i];
         ready_i = 1'b0;
      end
      @(negedge clk_i);
      valid_i = 1'b0;
      check("pending valid_o", 32'(valid_o), 32'd1);
      check("pending operand_o", operand_o, 32'hDEADBEEF);
      do_reset();
      check_reset_state("pending reset");
      build_packet(8'h63, 16, 1'b0);
      run(0, 1'b0);

      // Random packet mixes
      for (int r = 0; r < 4; r++) begin
         for (int p = 0; p < 6; p++) begin
            build_packet(opc_tbl[$urandom_range(4)], len_tbl[$urandom_range(9)], 1'b0);
         end
         run(r, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
